// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads one word per instruction over req/valid,
// holds it in IR for decode, and commits PC+1 or the branch target when execute completes.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [15:0]       COMMAND,
  output logic              cmd_valid,
  input  logic              exec_done,
  input  logic              PC_load,
  input  logic [15:0]       branch_target,
  input  logic              flag_s,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              flag_v,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;

  logic is_hlt, is_uncond, cond_true, taken;

  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign pc_out    = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == FETCH);
  assign cmd_valid = (state_q == ISSUE);
  assign halted    = (state_q == HALT);
  assign COMMAND   = ir_q;

  assign is_hlt    = (ir_q[15:14] == 2'b11) && (ir_q[7:4] == 4'b1111);
  assign is_uncond = (ir_q[13:11] == 3'b100);

  // Carry flag has no branch condition that uses it; it is accepted for interface completeness.
  always_comb begin
    cond_true = 1'b0;
    case (ir_q[10:8])
      3'b000:  cond_true = flag_z;
      3'b001:  cond_true = flag_s ^ flag_v;
      3'b010:  cond_true = flag_z | (flag_s ^ flag_v);
      3'b011:  cond_true = ~flag_z;
      default: cond_true = 1'b0 & flag_c;
    endcase
  end

  assign taken = PC_load & (is_uncond | cond_true);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = WAIT;
      WAIT: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // HLT retires on its own; execute is never consulted for it.
        if (is_hlt) begin
          pc_d    = pc_plus1;
          state_d = HALT;
        end else if (exec_done) begin
          pc_d    = taken ? branch_target[ADDR_W-1:0] : pc_plus1;
          state_d = FETCH;
        end
      end
      HALT:    if (start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 16-bit instance for the main sequences and a 4-bit
// instance reset to PC=4'hF for address wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, start4;
  logic [15:0] imem_rdata, branch_target;
  logic        imem_valid, exec_done, PC_load;
  logic        flag_s, flag_z, flag_c, flag_v;

  logic        imem_req, cmd_valid, halted;
  logic [15:0] imem_addr, COMMAND, pc_out, pc_plus1;

  logic        imem_req4, cmd_valid4, halted4;
  logic [3:0]  imem_addr4, pc_out4, pc_plus1_4;
  logic [15:0] COMMAND4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .COMMAND(COMMAND), .cmd_valid(cmd_valid), .exec_done(exec_done), .PC_load(PC_load),
    .branch_target(branch_target), .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .halted(halted)
  );

  fetch_unit #(.ADDR_W(4), .RESET_PC(4'hF)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .imem_req(imem_req4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .COMMAND(COMMAND4), .cmd_valid(cmd_valid4), .exec_done(exec_done), .PC_load(PC_load),
    .branch_target(branch_target), .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .pc_out(pc_out4), .pc_plus1(pc_plus1_4), .halted(halted4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called while in FETCH: memory answers in the first WAIT cycle, leaving the DUT in ISSUE.
  task automatic fetch_issue(input logic [15:0] word);
    step();
    imem_rdata = word;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
  endtask

  task automatic complete(input logic pl, input logic [15:0] tgt,
                          input logic s, input logic z, input logic v);
    PC_load = pl; branch_target = tgt;
    flag_s = s; flag_z = z; flag_v = v;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0; PC_load = 1'b0;
    flag_s = 1'b0; flag_z = 1'b0; flag_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    imem_rdata = 16'h0; imem_valid = 1'b0; exec_done = 1'b0; PC_load = 1'b0;
    branch_target = 16'h0; flag_s = 1'b0; flag_z = 1'b0; flag_c = 1'b0; flag_v = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_command", {16'b0, COMMAND}, 32'h0000);
    chk("rst_pc", {16'b0, pc_out}, 32'h0000);
    step();
    chk("idle_no_req", {31'b0, imem_req}, 32'd0);

    // First fetch: ADD at address 0, three cycles from start to cmd_valid.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fetch0_req", {31'b0, imem_req}, 32'd1);
    chk("fetch0_addr", {16'b0, imem_addr}, 32'h0000);
    step();
    chk("wait_req_low", {31'b0, imem_req}, 32'd0);
    chk("wait_cmd_low", {31'b0, cmd_valid}, 32'd0);
    imem_rdata = 16'hC000; imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("issue_cmd_valid", {31'b0, cmd_valid}, 32'd1);
    chk("issue_command", {16'b0, COMMAND}, 32'hC000);
    step();
    chk("issue_holds", {31'b0, cmd_valid}, 32'd1);
    complete(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("add_next_req", {31'b0, imem_req}, 32'd1);
    chk("add_next_addr", {16'b0, imem_addr}, 32'h0001);

    fetch_issue(16'hA005);
    complete(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    chk("b_taken_addr", {16'b0, imem_addr}, 32'h0010);

    fetch_issue(16'hBB02);
    complete(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0);
    chk("bne_z1_addr", {16'b0, imem_addr}, 32'h0011);

    fetch_issue(16'hBB02);
    complete(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    chk("bne_z0_addr", {16'b0, imem_addr}, 32'h0020);

    fetch_issue(16'hB900);
    complete(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
    chk("blt_s1v0_addr", {16'b0, imem_addr}, 32'h0040);

    fetch_issue(16'hB900);
    complete(1'b1, 16'h0060, 1'b1, 1'b0, 1'b1);
    chk("blt_s1v1_addr", {16'b0, imem_addr}, 32'h0041);

    fetch_issue(16'hA005);
    complete(1'b0, 16'h0070, 1'b0, 1'b0, 1'b0);
    chk("b_no_pcload_addr", {16'b0, imem_addr}, 32'h0042);

    fetch_issue(16'hA005);
    complete(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
    chk("b_to_7_addr", {16'b0, imem_addr}, 32'h0007);

    // HLT at pc=7 halts on its own; exec_done in HALT changes nothing.
    fetch_issue(16'hC0F0);
    chk("hlt_issue_valid", {31'b0, cmd_valid}, 32'd1);
    step();
    chk("hlt_halted", {31'b0, halted}, 32'd1);
    chk("hlt_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("hlt_pc", {16'b0, pc_out}, 32'h0008);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("hlt_ignores_done", {31'b0, halted}, 32'd1);
    chk("hlt_no_req", {31'b0, imem_req}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", {16'b0, imem_addr}, 32'h0008);
    chk("resume_pc_plus1", {16'b0, pc_plus1}, 32'h0009);
    chk("resume_not_halted", {31'b0, halted}, 32'd0);

    // Reset while waiting on memory; the late response must be dropped.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rdata = 16'h1234; imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    chk("rstwait_command", {16'b0, COMMAND}, 32'h0000);
    chk("rstwait_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rstwait_req", {31'b0, imem_req}, 32'd0);
    chk("rstwait_pc", {16'b0, pc_out}, 32'h0000);
    step();
    chk("rstwait_idle_req", {31'b0, imem_req}, 32'd0);

    // 4-bit instance: non-branch at pc=4'hF wraps to 0.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("w4_req", {31'b0, imem_req4}, 32'd1);
    chk("w4_addr", {28'b0, imem_addr4}, 32'hF);
    chk("w4_pc_plus1", {28'b0, pc_plus1_4}, 32'h0);
    fetch_issue(16'hC000);
    chk("w4_cmd_valid", {31'b0, cmd_valid4}, 32'd1);
    complete(1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
    chk("w4_wrap_addr", {28'b0, imem_addr4}, 32'h0);
    chk("w4_wrap_req", {31'b0, imem_req4}, 32'd1);
    chk("w4_dut16_idle", {31'b0, imem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
